// File: rtl/alu_deframer.sv
// Frame deframer: checks frame length against a programmable limit and buffers
// accepted words in an 8-deep FIFO toward the consumer.
module alu_deframer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame,
   input  logic [31:0] frame_data,
   input  logic [4:0]  frame_len,
   input  logic        frame_len_val,
   output logic        deframe_bp,
   output logic        out_val,
   output logic [31:0] out_data,
   input  logic        out_rdy,
   output logic        frame_done,
   output logic        frame_err,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, BODY, ERR} state_t;

   state_t      state, state_nxt;
   logic [4:0]  len_q;
   logic [5:0]  wcnt, wcnt_nxt;
   logic [5:0]  len_words;
   logic        push, done_nxt, err_nxt;

   logic [31:0] mem [8];
   logic [2:0]  wptr, rptr;
   logic [3:0]  cnt;
   logic        pop, wr;

   assign len_words = {1'b0, len_q} + 6'd1;

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      push      = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      unique case (state)
         IDLE: if (frame) begin
            push      = 1'b1;
            wcnt_nxt  = 6'd1;
            state_nxt = BODY;
         end
         BODY: if (frame) begin
            if (wcnt < len_words) begin
               push     = 1'b1;
               wcnt_nxt = wcnt + 6'd1;
            end else begin
               // word L+1: reject it and swallow the rest of the frame
               err_nxt   = 1'b1;
               state_nxt = ERR;
            end
         end else begin
            state_nxt = IDLE;
            if (wcnt == len_words) done_nxt = 1'b1;
            else                   err_nxt  = 1'b1;
         end
         ERR: if (!frame) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign pop = out_rdy && (cnt != 4'd0);
   assign wr  = push && ((cnt != 4'd8) || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         len_q      <= 5'd3;
         wcnt       <= 6'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         wptr       <= 3'd0;
         rptr       <= 3'd0;
         cnt        <= 4'd0;
         ovf        <= 1'b0;
         deframe_bp <= 1'b0;
      end else begin
         state      <= state_nxt;
         wcnt       <= wcnt_nxt;
         frame_done <= done_nxt;
         frame_err  <= err_nxt;
         if (state == IDLE && frame_len_val) len_q <= frame_len;
         if (wr)  wptr <= wptr + 3'd1;
         if (pop) rptr <= rptr + 3'd1;
         unique case ({wr, pop})
            2'b10:   cnt <= cnt + 4'd1;
            2'b01:   cnt <= cnt - 4'd1;
            default: cnt <= cnt;
         endcase
         if (push && !wr) ovf <= 1'b1;
         deframe_bp <= (cnt >= 4'd6);
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= frame_data;
   end

   assign out_val  = (cnt != 4'd0);
   assign out_data = out_val ? mem[rptr] : 32'd0;

endmodule

// File: doc/alu_deframer.md
ALU_DEFRAMER -- requirements
Module: alu_deframer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  block clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 frame  input  1  high for each cycle carrying one frame word; a frame is one contiguous run of frame-high cycles.
REQ-005 frame_data  input  32  frame word, sampled when frame=1.
REQ-006 frame_len  input  5  expected frame length code; length = frame_len+1 words (1..32).
REQ-007 frame_len_val  input  1  load strobe for frame_len.
REQ-008 deframe_bp  output  1  backpressure to the frame source.
REQ-009 out_val  output  1  out_data holds a valid word.
REQ-010 out_data  output  32  FIFO head word.
REQ-011 out_rdy  input  1  consumer accepts the word when out_val=1 and out_rdy=1.
REQ-012 frame_done  output  1  one-cycle pulse: a frame of correct length ended.
REQ-013 frame_err  output  1  one-cycle pulse: length error detected.
REQ-014 ovf  output  1  sticky flag: at least one word was dropped because the FIFO was full.

Function
REQ-015 Length register: reset value 5'd3 (4 words); loaded from frame_len when frame_len_val=1 in IDLE; ignored in BODY/ERR.
REQ-016 FSM states: IDLE, BODY, ERR.
REQ-017 IDLE: frame=1 -> push word, word count=1, go to BODY; if the length is 1 word, stay in BODY until frame falls.
REQ-018 BODY: frame=1 and count<L -> push word, count+1.
REQ-019 BODY: frame=1 and count==L (word L+1 arriving) -> word not pushed, frame_err pulse next cycle, go to ERR.
REQ-020 BODY: frame=0 -> go to IDLE; count==L -> frame_done pulse, else frame_err pulse, in the following cycle.
REQ-021 ERR: discard all words while frame=1; frame=0 -> go to IDLE with no further pulse.
REQ-022 frame_done and frame_err SHALL never be high together and SHALL be high for exactly one cycle per event.
REQ-023 Back-to-back frames need at least one frame=0 cycle between them; the frame=0 cycle ending a frame is the separator.
REQ-024 FIFO: 8 entries x 32 bits, circular, 3-bit read/write pointers with wrap from 7 to 0, 4-bit occupancy count 0..8.
REQ-025 out_val = (count!=0); out_data = head entry, stable while out_val=1 and out_rdy=0.
REQ-026 Push when full with no pop in the same cycle -> word dropped, ovf set; the FSM still counts the word.
REQ-027 Push and pop in the same cycle: both succeed, count unchanged, including when the FIFO is full or holds one word.
REQ-028 Pop on empty SHALL have no effect.
REQ-029 deframe_bp = registered (count>=6), giving the source 2 cycles of slack.
REQ-030 Words of a short or long frame already pushed SHALL still be delivered; only frame_err marks the fault.

Reset
REQ-031 Reset SHALL set: FSM=IDLE, length=5'd3, pointers/count=0, out_val=0, out_data=0, frame_done=0, frame_err=0, ovf=0, deframe_bp=0.
REQ-032 Reset mid-frame SHALL discard FIFO contents and the partial frame; after release, frame=1 with no preceding frame=0 is treated as a new frame start.
REQ-033 ovf SHALL clear only on reset.

Verification
REQ-034 frame_len=3 loaded, 4-word frame A0..A3, out_rdy=1 -> A0..A3 out in order, frame_done single pulse, frame_err never asserted.
REQ-035 frame_len=3, 2-word frame -> 2 words delivered, frame_err pulse one cycle after frame falls, no frame_done.
REQ-036 frame_len=3, 6-word frame -> first 4 delivered, frame_err one cycle after word 5, words 5-6 discarded, no frame_done.
REQ-037 out_rdy=0, frame_len=9, 10-word frame -> deframe_bp high from count 6, words 9-10 dropped, ovf=1 held; out_rdy=1 then returns the first 8 words in order.
REQ-038 FIFO at 8 entries, push+pop in the same cycle -> count stays 8, no drop, ovf stays 0, order preserved across pointer wrap.
REQ-039 rst_n low during word 2 of a frame -> all outputs at reset values; next frame after release is received correctly.
